// File: rtl/fp_sqrt_mant_core.sv
// -----------------------------------------------------------------------------
// fp_sqrt_mant_core
//
// Iterative radix-2 restoring integer square root for the mantissa datapath.
// Produces one root bit per clock. A requester pulses start_i with a
// 2*ROOT_WIDTH-bit radicand and then waits for the single-cycle done_o pulse.
// Exponent, sign and special cases are handled by the front end.
//
// Handshake: start_i is a request strobe that is accepted only on an edge
// where the engine is in IDLE or DONE; in CALC it is ignored (not queued).
// done_o is high for exactly one cycle per accepted, non-aborted request, and
// root_o/rem_o/sticky_o are valid from that cycle until the next completion.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous, active-high reset (aborts any running operation)
//   start_i      request strobe
//   radicand_i   unsigned radicand, sampled on the accepting edge only
//   busy_o       high while iterating (CALC)
//   done_o       single-cycle result-valid pulse
//   root_o       floor(sqrt(radicand))
//   rem_o        radicand - root^2
//   sticky_o     OR of rem_o (inexact indicator)
//   dbg_state_o  current FSM state (IDLE=0, CALC=1, DONE=2)
// -----------------------------------------------------------------------------
module fp_sqrt_mant_core #(
    parameter int ROOT_WIDTH = 26
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [2*ROOT_WIDTH-1:0]   radicand_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [ROOT_WIDTH-1:0]     root_o,
    output logic [ROOT_WIDTH:0]       rem_o,
    output logic                      sticky_o,
    output logic [1:0]                dbg_state_o
);

    localparam int RW   = ROOT_WIDTH;
    localparam int DW   = 2 * ROOT_WIDTH;
    localparam int REMW = ROOT_WIDTH + 2;
    localparam int CW   = $clog2(ROOT_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_rad;
    logic [REMW-1:0]   r_rem;
    logic [RW-1:0]     r_root;
    logic              r_done;
    logic [RW-1:0]     r_root_out;
    logic [RW:0]       r_rem_out;
    logic              r_sticky;

    logic              w_accept;
    logic [REMW-1:0]   w_r_shift;
    logic [REMW-1:0]   w_trial;
    logic              w_ge;
    logic [REMW-1:0]   w_r_next;
    logic [RW-1:0]     w_q_next;

    // A new request is taken only when no operation is running.
    assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    // One restoring step. The partial remainder never exceeds twice the
    // partial root, so shifting it left by two cannot lose set bits in the
    // REMW-bit register, and the trial value (Q<<2)|1 fits the same width.
    assign w_r_shift = (r_rem << 2) | {{(REMW-2){1'b0}}, r_rad[DW-1:DW-2]};
    assign w_trial   = {r_root, 2'b01};
    assign w_ge      = (w_r_shift >= w_trial);
    assign w_r_next  = w_ge ? (w_r_shift - w_trial) : w_r_shift;
    // The root's top bit is always zero before the final step, so it can be
    // shifted out freely.
    assign w_q_next  = {r_root[RW-2:0], w_ge};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_done     <= 1'b0;
            r_root_out <= '0;
            r_rem_out  <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Result registers are deliberately left untouched here so
                // the previous answer stays visible until the next done.
                r_rad   <= radicand_i;
                r_rem   <= '0;
                r_root  <= '0;
                r_cnt   <= CW'(RW - 1);
                r_state <= S_CALC;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_CALC: begin
                        r_rem  <= w_r_next;
                        r_root <= w_q_next;
                        r_rad  <= {r_rad[DW-3:0], 2'b00};
                        if (r_cnt == '0) begin
                            r_root_out <= w_q_next;
                            r_rem_out  <= w_r_next[RW:0];
                            r_sticky   <= |w_r_next[RW:0];
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o      = (r_state == S_CALC);
    assign done_o      = r_done;
    assign root_o      = r_root_out;
    assign rem_o       = r_rem_out;
    assign sticky_o    = r_sticky;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fp_sqrt_mant_core.sv
module tb_fp_sqrt_mant_core;

    localparam int RW  = 26;
    localparam int DW  = 2 * RW;
    localparam int LAT = RW;   // edges from the accepting edge to the edge raising done

    typedef struct {
        logic [RW-1:0] root;
        logic [RW:0]   rem;
        logic          sticky;
        int            cyc;
        logic [DW-1:0] rad;
    } exp_t;

    logic            clk_i;
    logic            reset_i;
    logic            start_i;
    logic [DW-1:0]   radicand_i;
    logic            busy_o;
    logic            done_o;
    logic [RW-1:0]   root_o;
    logic [RW:0]     rem_o;
    logic            sticky_o;
    logic [1:0]      dbg_state_o;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   busy_cnt;
    logic prev_done;

    fp_sqrt_mant_core #(.ROOT_WIDTH(RW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .radicand_i  (radicand_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .root_o      (root_o),
        .rem_o       (rem_o),
        .sticky_o    (sticky_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d results still pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic exp_t ref_sqrt(input logic [DW-1:0] x, input int acc_cyc);
        exp_t e;
        longint unsigned xv;
        longint unsigned r;
        xv = longint'(x);
        r  = longint'($sqrt(real'(xv)));
        while (r * r > xv) r = r - 1;
        while ((r + 1) * (r + 1) <= xv) r = r + 1;
        e.root   = RW'(r);
        e.rem    = (RW+1)'(xv - r * r);
        e.sticky = (xv != r * r);
        e.cyc    = acc_cyc + LAT;
        e.rad    = x;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Drives a one-cycle start; the edge after this negedge accepts it.
    task automatic issue(input logic [DW-1:0] x);
        @(negedge clk_i);
        start_i    = 1'b1;
        radicand_i = x;
        @(posedge clk_i);
        #1;
        exp_q.push_back(ref_sqrt(x, cyc));
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_rad();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return DW'(v[15:0]);
            1:       return DW'(v[31:0]);
            default: return v[DW-1:0];
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o !== 1'b0) begin
                n_checks++;
                if (prev_done === 1'b1) begin
                    n_fail++;
                    $display("FAIL done_pulse_width: done high on consecutive cycles at cycle %0d", cyc);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done at cycle %0d with no pending request, root=0x%0h", cyc, root_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (root_o !== e.root || rem_o !== e.rem || sticky_o !== e.sticky || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL result rad=0x%0h: got root=0x%0h rem=0x%0h sticky=%0b cyc=%0d required root=0x%0h rem=0x%0h sticky=%0b cyc=%0d",
                                 e.rad, root_o, rem_o, sticky_o, cyc, e.root, e.rem, e.sticky, e.cyc);
                    end
                end
            end
            prev_done = done_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_i    = 1'b1;
        start_i    = 1'b0;
        radicand_i = '0;
        busy_cnt   = 0;
        n_checks   = 0;
        n_fail     = 0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;

        check1("reset_busy",   64'(busy_o),   64'd0);
        check1("reset_done",   64'(done_o),   64'd0);
        check1("reset_root",   64'(root_o),   64'd0);
        check1("reset_rem",    64'(rem_o),    64'd0);
        check1("reset_sticky", 64'(sticky_o), 64'd0);

        // Exact square, latency and busy duration.
        busy_cnt = 0;
        issue(DW'(144));
        wait_idle();
        check1("busy_cycles_144", 64'(busy_cnt), 64'(RW));

        // Small inexact, FP32 1.0 significand, maximum radicand, zero.
        issue(DW'(2));
        wait_idle();
        issue(DW'(1) << 50);
        wait_idle();
        issue({DW{1'b1}});
        wait_idle();
        issue(DW'(0));
        wait_idle();

        // Output hold through IDLE.
        issue(DW'(50));
        wait_idle();
        repeat (3) @(negedge clk_i);
        check1("hold_root_50", 64'(root_o), 64'd7);
        check1("hold_rem_50",  64'(rem_o),  64'd1);

        // Start pulsed mid-CALC is ignored.
        issue(DW'(500));
        repeat (4) @(negedge clk_i);
        start_i    = 1'b1;
        radicand_i = DW'(777777);
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk_i);

        // Back-to-back: start in the DONE cycle.
        issue(DW'(16));
        repeat (LAT - 1) @(negedge clk_i);
        issue(DW'(9));
        wait_idle();

        // start_i held high: one new operation per LAT+1 cycles.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            start_i    = 1'b1;
            radicand_i = rand_rad();
            @(posedge clk_i);
            #1;
            exp_q.push_back(ref_sqrt(radicand_i, cyc));
            for (int j = 0; j < LAT; j++) begin
                @(negedge clk_i);
                radicand_i = rand_rad();
                if (k == 3) start_i = 1'b0;
                @(posedge clk_i);
            end
        end
        wait_idle();

        // Reset in the middle of an operation aborts it.
        issue(DW'(1000));
        repeat (9) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        exp_q.delete();
        check1("abort_busy",   64'(busy_o),   64'd0);
        check1("abort_done",   64'(done_o),   64'd0);
        check1("abort_root",   64'(root_o),   64'd0);
        check1("abort_rem",    64'(rem_o),    64'd0);
        check1("abort_sticky", 64'(sticky_o), 64'd0);
        repeat (40) @(negedge clk_i);
        issue(DW'(25));
        wait_idle();

        // Randomised operations.
        for (int k = 0; k < 20; k++) begin
            issue(rand_rad());
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        repeat (5) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_mant_core.md
Name: fp_sqrt_mant_core

Overview:
- Iterative radix-2 restoring integer square-root engine for the mantissa datapath.
- Responder side of the start/done handshake: a requester (fp_sqrt-style front end or bench) pulses start with a radicand, then waits for done.
- Produces the root, the final remainder and a sticky bit, which the front end packs into uround_res_t before fp_rnd.
- One result bit per clock. No exponent, sign or special-case handling in this block.

Parameters:
- ROOT_WIDTH, 26, root bits produced: FP32 24-bit significand + guard + round. Radicand is 2*ROOT_WIDTH bits.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  reset, synchronous, active-high
- start_i  in  1  request strobe; sampled only in IDLE or DONE
- radicand_i  in  2*ROOT_WIDTH  unsigned radicand; sampled on the accepting edge only
- busy_o  out  1  high in CALC
- done_o  out  1  single-cycle pulse, result valid
- root_o  out  ROOT_WIDTH  floor(sqrt(radicand))
- rem_o  out  ROOT_WIDTH+1  radicand - root^2
- sticky_o  out  1  OR-reduction of rem_o (inexact indicator)

Behaviour:
- Reset (reset_i high at an edge, any state, including mid-CALC):
  - state to IDLE.
  - busy_o=0, done_o=0, root_o=0, rem_o=0, sticky_o=0.
  - Iteration counter and radicand shift register cleared.
  - No done pulse for an aborted operation.
- States: IDLE, CALC, DONE.
  - IDLE: start_i=1 latches radicand_i into the shift register, clears the partial root and remainder, loads counter=ROOT_WIDTH-1, goes to CALC. start_i=0 stays in IDLE.
  - CALC: one iteration per edge. When counter==0 at an edge, the final iteration completes, results are registered and the state goes to DONE. Otherwise counter decrements.
  - DONE: done_o=1 for exactly this cycle.
    - start_i=1: accepted as in IDLE and goes directly to CALC (back-to-back, no bubble).
    - start_i=0: goes to IDLE.
  - start_i in CALC is ignored. It is not queued and does not alter the running operation.
- Iteration (restoring), internal remainder R of ROOT_WIDTH+2 bits, partial root Q:
  - R' = (R<<2) | top two radicand bits; radicand register shifts left by 2.
  - T = (Q<<2) | 1.
  - If R' >= T: R = R' - T, Q = (Q<<1)|1.
  - Else: R = R', Q = Q<<1.
- Latency:
  - Start accepted at edge E0; done_o is high during the cycle following edge E(ROOT_WIDTH).
  - Equivalently, done_o is first seen ROOT_WIDTH+1 cycles after start_i is sampled: 27 cycles at default.
  - Throughput: one operation per ROOT_WIDTH+1 cycles with back-to-back start in DONE.
- Output hold:
  - root_o, rem_o and sticky_o update only at the edge entering DONE.
  - They hold their values through IDLE until the next completion; a new start does not clear them.
  - busy_o is combinational from state (CALC).
- Width guarantees:
  - rem_o <= 2*root_o, so it always fits ROOT_WIDTH+1 bits.
  - The internal ROOT_WIDTH+2-bit remainder prevents overflow of the trial compare.
- Boundaries:
  - radicand=0 gives root 0, rem 0, sticky 0.
  - Maximal radicand gives no overflow.
  - start_i held high continuously gives back-to-back operations, each taking a new radicand_i at its accepting edge.

Test Plan:
- Reset, then start with radicand=144 -> done_o exactly one cycle, 27 cycles after start; root_o=12, rem_o=0, sticky_o=0, busy_o high for 26 cycles.
- radicand=2 -> root_o=1, rem_o=1, sticky_o=1. Then radicand=1<<50 (FP32 1.0 significand) -> root_o=1<<25, rem_o=0, sticky_o=0.
- radicand=2^52-1 -> root_o=0x3FFFFFF, rem_o=0x7FFFFFE, sticky_o=1; no overflow.
- start_i pulsed again mid-CALC with a different radicand -> ignored; result still matches the first radicand, exactly one done pulse.
- start_i asserted in the DONE cycle with radicand=9 after radicand=16 -> first done gives root_o=4; second done gives root_o=3, rem_o=0, exactly 27 cycles after the DONE-cycle start.
- reset_i asserted for one cycle at iteration 10 of a running op -> next cycle busy_o=0, done_o=0, all outputs 0, no done pulse follows. A subsequent start with radicand=25 gives root_o=5.
